// File: rtl/fft_pkg.sv
// Shared constants, types and the sine table for the 64-point FFT datapath.
// TWIDDLE_CONJ_EN (optional) adds conjugated twiddles for the inverse transform.
package fft_pkg;

    localparam int D_WIDTH      = 64;
    localparam int LOG_2_WIDTH  = 6;
    localparam int DATA_W       = 16;
    localparam int TW_W         = 9;
    localparam int QUARTER_TURN = 16;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [TW_W-1:0]   twiddle_t;
    typedef logic [LOG_2_WIDTH-1:0]   index_t;

    localparam twiddle_t TW_MAX = 9'sd255;
    localparam twiddle_t TW_MIN = -9'sd256;

    // T[i] = round(256*sin(2*pi*i/64)), ties away from zero, clamped to [-256,255]
    localparam twiddle_t TW_TABLE [D_WIDTH] = '{
          9'sd0,    9'sd25,   9'sd50,   9'sd74,   9'sd98,   9'sd121,  9'sd142,  9'sd162,
          9'sd181,  9'sd198,  9'sd213,  9'sd226,  9'sd237,  9'sd245,  9'sd251,  9'sd255,
          9'sd255,  9'sd255,  9'sd251,  9'sd245,  9'sd237,  9'sd226,  9'sd213,  9'sd198,
          9'sd181,  9'sd162,  9'sd142,  9'sd121,  9'sd98,   9'sd74,   9'sd50,   9'sd25,
          9'sd0,   -9'sd25,  -9'sd50,  -9'sd74,  -9'sd98,  -9'sd121, -9'sd142, -9'sd162,
         -9'sd181, -9'sd198, -9'sd213, -9'sd226, -9'sd237, -9'sd245, -9'sd251, -9'sd255,
         -9'sd256, -9'sd255, -9'sd251, -9'sd245, -9'sd237, -9'sd226, -9'sd213, -9'sd198,
         -9'sd181, -9'sd162, -9'sd142, -9'sd121, -9'sd98,  -9'sd74,  -9'sd50,  -9'sd25
    };

endpackage

// File: rtl/twiddle_operand_fetch_if.sv
// Fetch request/response bundle between the FFT controller and the butterfly.
// The ifft select exists only when TWIDDLE_CONJ_EN is defined.
interface twiddle_operand_fetch_if;
    import fft_pkg::*;

    logic     en;
    index_t   tw_index;
    index_t   idx_a;
    index_t   idx_b;
    sample_t  regs_re [D_WIDTH];
    sample_t  regs_im [D_WIDTH];
`ifdef TWIDDLE_CONJ_EN
    logic     ifft;
`endif
    twiddle_t tw_re;
    twiddle_t tw_im;
    sample_t  a_re;
    sample_t  a_im;
    sample_t  b_re;
    sample_t  b_im;
    logic     valid;

    modport master (
        output en, tw_index, idx_a, idx_b, regs_re, regs_im,
`ifdef TWIDDLE_CONJ_EN
        output ifft,
`endif
        input  tw_re, tw_im, a_re, a_im, b_re, b_im, valid
    );

    modport slave (
        input  en, tw_index, idx_a, idx_b, regs_re, regs_im,
`ifdef TWIDDLE_CONJ_EN
        input  ifft,
`endif
        output tw_re, tw_im, a_re, a_im, b_re, b_im, valid
    );

endinterface

// File: rtl/twiddle_rom.sv
// Combinational lookup into the shared 64-entry sine table.
// Unaffected by TWIDDLE_CONJ_EN.
module twiddle_rom
    import fft_pkg::*;
(
    input  index_t   index,
    output twiddle_t value
);

    assign value = TW_TABLE[index];

endmodule

// File: rtl/twiddle_operand_fetch.sv
// One-cycle registered fetch of a twiddle factor and two register-file operands.
// TWIDDLE_CONJ_EN adds the ifft select that negates the imaginary twiddle.
module twiddle_operand_fetch
    import fft_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    twiddle_operand_fetch_if.slave bus
);

    index_t   re_index;
    twiddle_t rom_re;
    twiddle_t rom_im;
    twiddle_t im_next;

    twiddle_t tw_re_q;
    twiddle_t tw_im_q;
    sample_t  a_re_q;
    sample_t  a_im_q;
    sample_t  b_re_q;
    sample_t  b_im_q;
    logic     valid_q;

    // cos(x) = sin(x + quarter turn); the 6-bit add wraps modulo 64
    assign re_index = bus.tw_index + index_t'(QUARTER_TURN);

    twiddle_rom u_rom_re (.index(re_index),     .value(rom_re));
    twiddle_rom u_rom_im (.index(bus.tw_index), .value(rom_im));

`ifdef TWIDDLE_CONJ_EN
    // -(-256) is not representable in TW_W bits, so clamp it to +255
    always_comb begin
        im_next = rom_im;
        if (bus.ifft)
            im_next = (rom_im == TW_MIN) ? TW_MAX : -rom_im;
    end
`else
    assign im_next = rom_im;
`endif

    // The FFT register file updates on the falling edge; stay on the same edge
    always_ff @(negedge clk) begin
        if (!rst) begin
            tw_re_q <= '0;
            tw_im_q <= '0;
            a_re_q  <= '0;
            a_im_q  <= '0;
            b_re_q  <= '0;
            b_im_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.en;
            if (bus.en) begin
                tw_re_q <= rom_re;
                tw_im_q <= im_next;
                a_re_q  <= bus.regs_re[bus.idx_a];
                a_im_q  <= bus.regs_im[bus.idx_a];
                b_re_q  <= bus.regs_re[bus.idx_b];
                b_im_q  <= bus.regs_im[bus.idx_b];
            end
        end
    end

    assign bus.tw_re = tw_re_q;
    assign bus.tw_im = tw_im_q;
    assign bus.a_re  = a_re_q;
    assign bus.a_im  = a_im_q;
    assign bus.b_re  = b_re_q;
    assign bus.b_im  = b_im_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_twiddle_operand_fetch.sv
// Bench for twiddle_operand_fetch: sine-based reference model plus directed anchors.
// Exercises the ifft path when TWIDDLE_CONJ_EN is defined.
module tb_twiddle_operand_fetch;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int m_tw_re, m_tw_im, m_a_re, m_a_im, m_b_re, m_b_im, m_valid;

    twiddle_operand_fetch_if bus ();

    twiddle_operand_fetch dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic int tref(int i);
        real v;
        int  r;
        v = 256.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 64.0);
        if (v >= 0.0) r = $rtoi(v + 0.5);
        else          r = -$rtoi(-v + 0.5);
        if (r > 255)  r = 255;
        if (r < -256) r = -256;
        return r;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model update for the edge about to happen, from the inputs as driven now
    task automatic model_edge();
        int k, im;
        if (!rst) begin
            m_tw_re = 0; m_tw_im = 0; m_a_re = 0; m_a_im = 0;
            m_b_re = 0; m_b_im = 0; m_valid = 0;
        end else begin
            m_valid = int'(bus.en);
            if (bus.en) begin
                k  = int'(bus.tw_index);
                im = tref(k);
`ifdef TWIDDLE_CONJ_EN
                if (bus.ifft) begin
                    im = -im;
                    if (im > 255) im = 255;
                end
`endif
                m_tw_re = tref((k + 16) % 64);
                m_tw_im = im;
                m_a_re  = int'(bus.regs_re[bus.idx_a]);
                m_a_im  = int'(bus.regs_im[bus.idx_a]);
                m_b_re  = int'(bus.regs_re[bus.idx_b]);
                m_b_im  = int'(bus.regs_im[bus.idx_b]);
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(negedge clk);
        @(posedge clk);
        check("tw_re", bus.tw_re, m_tw_re);
        check("tw_im", bus.tw_im, m_tw_im);
        check("a_re",  bus.a_re,  m_a_re);
        check("a_im",  bus.a_im,  m_a_im);
        check("b_re",  bus.b_re,  m_b_re);
        check("b_im",  bus.b_im,  m_b_im);
        check("valid", {31'd0, bus.valid}, m_valid);
    endtask

    task automatic rand_inputs();
        bus.tw_index = index_t'($urandom);
        bus.idx_a    = index_t'($urandom);
        bus.idx_b    = index_t'($urandom);
        for (int i = 0; i < D_WIDTH; i++) begin
            bus.regs_re[i] = sample_t'($urandom);
            bus.regs_im[i] = sample_t'($urandom);
        end
`ifdef TWIDDLE_CONJ_EN
        bus.ifft = 1'b0;
`endif
    endtask

    initial begin
        int ks [6]    = '{0, 8, 16, 32, 48, 63};
        int exp_re [6] = '{255, 181, 0, -256, 0, 255};
        int exp_im [6] = '{0, 181, 255, 0, -256, -25};

        bus.en = 1'b1;
        rand_inputs();
        @(posedge clk);

        // reset held for two edges with en high
        rst = 1'b0;
        cycle();
        rand_inputs();
        cycle();

        rst = 1'b1;
        rand_inputs();
        cycle();

        // twiddle anchors
        for (int i = 0; i < 6; i++) begin
            bus.tw_index = index_t'(ks[i]);
            cycle();
            check("tw_re_anchor", bus.tw_re, exp_re[i]);
            check("tw_im_anchor", bus.tw_im, exp_im[i]);
        end

        // operand select
        for (int i = 0; i < D_WIDTH; i++) begin
            bus.regs_re[i] = sample_t'(3 * i);
            bus.regs_im[i] = sample_t'(-i);
        end
        bus.idx_a = 6'd5;
        bus.idx_b = 6'd37;
        cycle();
        check("a_re_sel", bus.a_re, 15);
        check("a_im_sel", bus.a_im, -5);
        check("b_re_sel", bus.b_re, 111);
        check("b_im_sel", bus.b_im, -37);
        bus.idx_a = 6'd63;
        bus.idx_b = 6'd63;
        cycle();
        check("a_re_same", bus.a_re, 189);
        check("b_im_same", bus.b_im, -63);

        // hold with en low
        bus.en = 1'b1;
        rand_inputs();
        cycle();
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            cycle();
        end

        // back-to-back with wrap of k
        bus.en = 1'b1;
        for (int k = 60; k < 68; k++) begin
            bus.tw_index = index_t'(k % 64);
            cycle();
        end
        bus.tw_index = 6'd50;
        cycle();
        check("tw_re_wrap50", bus.tw_re, 50);

        // reset mid-stream, then release with en low, then fetch
        rand_inputs();
        cycle();
        rst = 1'b0;
        rand_inputs();
        cycle();
        rst = 1'b1;
        bus.en = 1'b0;
        cycle();
        bus.en = 1'b1;
        rand_inputs();
        cycle();

`ifdef TWIDDLE_CONJ_EN
        bus.ifft = 1'b1;
        bus.tw_index = 6'd48;
        model_edge();
        @(negedge clk);
        @(posedge clk);
        check("conj_im48", bus.tw_im, 255);
        bus.tw_index = 6'd8;
        model_edge();
        @(negedge clk);
        @(posedge clk);
        check("conj_im8", bus.tw_im, -181);
        check("conj_re8", bus.tw_re, 181);
        bus.ifft = 1'b0;
        cycle();
        check("noconj_im8", bus.tw_im, 181);
`endif

        // random traffic with sporadic reset
        for (int n = 0; n < 300; n++) begin
            rand_inputs();
            bus.en = 1'($urandom_range(0, 3) != 0);
            rst    = ($urandom_range(0, 15) != 0);
`ifdef TWIDDLE_CONJ_EN
            bus.ifft = 1'($urandom);
`endif
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
